// File: rtl/dds_multi_if.sv
// dds_multi_if: configuration port and sample outputs of dds_multi.
interface dds_multi_if #(
    parameter int CHANNELS       = 4,
    parameter int DEPTH_BITWIDTH = 16,
    parameter int DATA_BITWIDTH  = 14
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic                              cfg_valid;
    logic                              cfg_ready;
    logic [CW-1:0]                     cfg_chan;
    logic [1:0]                        cfg_sel;
    logic [DEPTH_BITWIDTH-1:0]         cfg_data;
    logic                              update;
    logic                              phase_clr;
    logic                              out_valid;
    logic [CHANNELS*DATA_BITWIDTH-1:0] cos;
    logic [CHANNELS*DATA_BITWIDTH-1:0] sin;
    modport master (
        output cfg_valid, cfg_chan, cfg_sel, cfg_data, update, phase_clr,
        input  cfg_ready, out_valid, cos, sin
    );
    modport slave (
        input  cfg_valid, cfg_chan, cfg_sel, cfg_data, update, phase_clr,
        output cfg_ready, out_valid, cos, sin
    );
endinterface

// File: rtl/dds_multi.sv
// dds_multi: multi-channel quadrature DDS; shadowed per-channel config is committed to all channels at once.
module dds_multi #(
    parameter int CHANNELS       = 4,
    parameter int DEPTH_BITWIDTH = 16,
    parameter int LUT_BITWIDTH   = 10,
    parameter int DATA_BITWIDTH  = 14,
    parameter int AMP_BITWIDTH   = 8
) (
    input logic        clk,
    input logic        rstn,
    dds_multi_if.slave bus
);
    localparam int PW = DATA_BITWIDTH + AMP_BITWIDTH + 1;
    localparam real PI = 3.14159265358979323846;
    localparam logic [AMP_BITWIDTH-1:0] UNITY = AMP_BITWIDTH'(1) << (AMP_BITWIDTH - 1);
    localparam logic [LUT_BITWIDTH-1:0] QUARTER = LUT_BITWIDTH'(1) << (LUT_BITWIDTH - 2);
    localparam logic [DATA_BITWIDTH-1:0] OFFSET = DATA_BITWIDTH'(1) << (DATA_BITWIDTH - 1);

    logic signed [DATA_BITWIDTH-1:0] lut [2**LUT_BITWIDTH];
    logic [DEPTH_BITWIDTH-1:0] sh_f [CHANNELS];
    logic [DEPTH_BITWIDTH-1:0] sh_p [CHANNELS];
    logic [AMP_BITWIDTH-1:0] sh_a [CHANNELS];
    logic [DEPTH_BITWIDTH-1:0] act_f [CHANNELS];
    logic [DEPTH_BITWIDTH-1:0] act_p [CHANNELS];
    logic [AMP_BITWIDTH-1:0] act_a [CHANNELS];
    logic [DEPTH_BITWIDTH-1:0] acc [CHANNELS];
    logic [LUT_BITWIDTH-1:0] addr [CHANNELS];
    logic [AMP_BITWIDTH-1:0] amp1 [CHANNELS];
    logic [AMP_BITWIDTH-1:0] amp2 [CHANNELS];
    logic signed [DATA_BITWIDTH-1:0] sraw [CHANNELS];
    logic signed [DATA_BITWIDTH-1:0] craw [CHANNELS];
    logic [DATA_BITWIDTH-1:0] sout [CHANNELS];
    logic [DATA_BITWIDTH-1:0] cout [CHANNELS];
    logic ready;
    logic apply;
    logic wr;
    logic [2:0] vld;

    // Full-wave sine table, rounded half away from zero.
    for (genvar k = 0; k < 2**LUT_BITWIDTH; k++) begin : g_lut
        localparam real V = real'((1 << (DATA_BITWIDTH - 1)) - 1) *
                            $sin(2.0 * PI * k / real'(1 << LUT_BITWIDTH));
        localparam int R = V < 0.0 ? -$rtoi(0.5 - V) : $rtoi(V + 0.5);
        assign lut[k] = DATA_BITWIDTH'(R);
    end

    function automatic logic [DATA_BITWIDTH-1:0] scale(
        input logic signed [DATA_BITWIDTH-1:0] raw,
        input logic [AMP_BITWIDTH-1:0] amp
    );
        return DATA_BITWIDTH'((PW'(raw) * $signed(PW'(amp))) >>> (AMP_BITWIDTH - 1)) + OFFSET;
    endfunction

    assign wr = bus.cfg_valid & ready;

    // apply marks the single cycle in which shadows are copied; config writes are held off then.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready <= 1'b0;
            apply <= 1'b0;
            vld   <= '0;
        end else begin
            apply <= bus.update & ~apply;
            ready <= ~(bus.update & ~apply);
            vld   <= {vld[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sh_f[c]  <= '0;
                sh_p[c]  <= '0;
                sh_a[c]  <= UNITY;
                act_f[c] <= '0;
                act_p[c] <= '0;
                act_a[c] <= UNITY;
                acc[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr && int'(bus.cfg_chan) == c) begin
                    if (bus.cfg_sel == 2'd0) sh_f[c] <= bus.cfg_data;
                    if (bus.cfg_sel == 2'd1) sh_p[c] <= bus.cfg_data;
                    if (bus.cfg_sel == 2'd2) sh_a[c] <= bus.cfg_data[AMP_BITWIDTH-1:0];
                end
                if (apply) begin
                    act_f[c] <= sh_f[c];
                    act_p[c] <= sh_p[c];
                    act_a[c] <= sh_a[c];
                end
                acc[c] <= bus.phase_clr ? '0 : acc[c] + act_f[c];
            end
        end
    end

    // Amplitude travels alongside the phase so pword and amp changes land on the same sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                addr[c] <= '0;
                amp1[c] <= '0;
                amp2[c] <= '0;
                sraw[c] <= '0;
                craw[c] <= '0;
                sout[c] <= OFFSET;
                cout[c] <= OFFSET;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                addr[c] <= LUT_BITWIDTH'((acc[c] + act_p[c]) >> (DEPTH_BITWIDTH - LUT_BITWIDTH));
                amp1[c] <= act_a[c] > UNITY ? UNITY : act_a[c];
                sraw[c] <= lut[addr[c]];
                craw[c] <= lut[LUT_BITWIDTH'(addr[c] + QUARTER)];
                amp2[c] <= amp1[c];
                sout[c] <= scale(sraw[c], amp2[c]);
                cout[c] <= scale(craw[c], amp2[c]);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign bus.cos[c*DATA_BITWIDTH +: DATA_BITWIDTH] = cout[c];
        assign bus.sin[c*DATA_BITWIDTH +: DATA_BITWIDTH] = sout[c];
    end
    assign bus.out_valid = vld[2];
    assign bus.cfg_ready = ready;
endmodule

// File: doc/dds_multi.md
# dds_multi

Multi-channel, parametrised direct digital synthesiser that generates CHANNELS independent quadrature (cos/sin) outputs from per-channel frequency, phase and amplitude words. Configuration is written into per-channel shadow registers over a valid/ready port. A single `update` strobe commits the shadows to all channels in the same cycle, so retuning is phase-coherent and phase-continuous. The block sits between control logic and the DAC/mixer datapath, and supersedes the single-channel `dds`.

## Interface
- CHANNELS, 4, number of independent channels (≥1)
- DEPTH_BITWIDTH, 16, phase accumulator / fword / pword width
- LUT_BITWIDTH, 10, phase bits addressing the full-wave table (≤ DEPTH_BITWIDTH)
- DATA_BITWIDTH, 14, output sample width, offset binary
- AMP_BITWIDTH, 8, amplitude word width; 2^(AMP_BITWIDTH-1) = unity
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel; values ≥ CHANNELS ignored
- cfg_sel  in  2  0 = fword, 1 = pword, 2 = amp (low AMP_BITWIDTH bits), 3 = ignored
- cfg_data  in  DEPTH_BITWIDTH  write data
- update  in  1  commit all shadow registers to active registers
- phase_clr  in  1  zero all phase accumulators
- out_valid  out  1  cos/sin carry pipeline-filled data
- cos  out  CHANNELS*DATA_BITWIDTH  channel c at [c*DATA_BITWIDTH +: DATA_BITWIDTH]
- sin  out  CHANNELS*DATA_BITWIDTH  same packing

## Operation
- Per channel: shadow {fword, pword, amp}, active {fword, pword, amp}, accumulator acc.
- Write: on cfg_valid & cfg_ready, cfg_data goes to shadow[cfg_chan][cfg_sel]. Active registers are unaffected.
- Commit: `update` high in cycle N → active ← shadow for all channels at the end of cycle N+1 (apply cycle).
  - A write accepted in cycle N is included in the commit.
  - cfg_ready is low during the apply cycle only.
  - `update` during the apply cycle is ignored.
- Accumulator: acc ← acc + active fword every cycle, modulo 2^DEPTH_BITWIDTH. A commit never resets acc (phase-continuous).
- phase_clr in cycle N: every acc = 0 at the end of N, overriding the increment. Combined with `update` in the same cycle, both take effect.
- Phase: ph = acc + active pword (mod 2^DEPTH_BITWIDTH); table address a = ph[DEPTH_BITWIDTH-1 -: LUT_BITWIDTH].
- Table: T[k] = round((2^(DATA_BITWIDTH-1)-1)·sin(2πk/2^LUT_BITWIDTH)), signed, built at elaboration.
  - sin raw = T[a]
  - cos raw = T[(a + 2^(LUT_BITWIDTH-2)) mod 2^LUT_BITWIDTH]
- Amplitude: amp_eff = min(amp, 2^(AMP_BITWIDTH-1)); scaled = (raw·amp_eff) >>> (AMP_BITWIDTH-1), arithmetic, floor.
- Output: scaled + 2^(DATA_BITWIDTH-1), truncated to DATA_BITWIDTH bits; never overflows.
- Reset values:
  - shadow and active fword = 0, pword = 0, amp = 2^(AMP_BITWIDTH-1)
  - acc = 0; all pipeline registers cleared
  - cos = sin = 2^(DATA_BITWIDTH-1) on every channel
  - out_valid = 0; cfg_ready = 0

## Timing
- After rstn rises: cfg_ready = 1 at the first clock edge.
- Pipeline, 3 register stages:
  - S1: ph
  - S2: table read
  - S3: scale + offset → cos/sin
- Latency: acc value → outputs is 3 cycles.
- out_valid rises 3 cycles after the first post-reset edge and stays high until reset.
- New active words (committed at the end of N+1):
  - fword changes the acc increment from cycle N+2.
  - pword/amp reach the outputs 3 cycles after the apply edge.
- All channels change in the same cycle; channels with unchanged shadows see no discontinuity.
- rstn low at any time: immediate asynchronous return to reset values. A pending commit is discarded.

## Test plan
Defaults throughout: DEPTH 16, LUT 10, DATA 14, AMP 8, CHANNELS 4.
- Reset and idle: during reset every cos/sin = 8192 and out_valid = 0. After release with no writes, out_valid = 1 at cycle 3, every sin = 8192, every cos = 16383.
- Frequency: write ch1 fword = 16384, pulse `update`.
  - ch1 sin repeats 8192, 16383, 8192, 1; cos leads by one sample.
  - ch0/2/3 unchanged.
  - cfg_ready low exactly one cycle after the update cycle.
- Shadowing: write ch0 pword = 16384 without `update` → outputs unchanged for 20 cycles. Then `update` with a simultaneous write of ch0 amp = 64 → both committed: ch0 sin = 12287, cos = 8192.
- Amplitude clamp: ch2 pword = 16384, amp = 200 → sin = 16383. amp = 0 → sin = cos = 8192.
- Phase continuity and clear:
  - ch3 fword 1024 → 2048 mid-run: acc has no jump; increment changes at N+2.
  - phase_clr: all acc = 0 next cycle; cos returns to 16383 three cycles later on channels with fword = 0.
- Async reset mid-run: rstn low between edges → outputs 8192 and cfg_ready 0 immediately. After release all config is back to defaults; a pending commit is lost.
